swervolf_irq_router: RTL and testbench



---
 rtl/swervolf_irq_router_if.sv | 15 +
 rtl/swervolf_irq_router.sv | 155 +++++++++++++++
 tb/tb_swervolf_irq_router.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/swervolf_irq_router_if.sv
// Wishbone slave bundle for the interrupt router: 5-bit byte address, 32-bit data,
// registered read data and a single-cycle ack.
interface swervolf_irq_router_if;
    logic [4:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [31:0] rdt;
    logic        ack;

    modport master (output adr, dat, sel, we, cyc, stb, input rdt, ack);
    modport slave  (input adr, dat, sel, we, cyc, stb, output rdt, ack);
endinterface

// File: rtl/swervolf_irq_router.sv
// Routes N_SRC peripheral interrupts onto IRQ3/IRQ4, one source per line through claim/complete.
// Define IRQ_ROUTER_TIMEOUT_EN to add the per-line in-service watchdog and sticky STATUS bits.
module swervolf_irq_router #(
    parameter int N_SRC          = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_SRC-1:0]     i_src,
    swervolf_irq_router_if.slave wb,
    output logic                 o_irq3,
    output logic                 o_irq4
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ASSERT  = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;

    logic [N_SRC-1:0]      src_d, pending, enable, route, edge_en, set_v, clr_v;
    logic [1:0][N_SRC-1:0] cand;
    logic [1:0][1:0]       state;
    logic [1:0][4:0]       rec_id, win_id;
    logic [1:0]            win_vld, take, done, tmo, status;
    logic [2:0]            word;
    logic                  acc, wr, rd;
    logic [31:0]           rdata;
    logic                  unused_bits;

    assign word = wb.adr[4:2];
    assign acc  = wb.cyc & wb.stb & ~wb.ack;
    assign wr   = acc & wb.we & wb.sel[0];
    assign rd   = acc & ~wb.we;

    // Level sources set every cycle they are high; edge sources only on a 0->1 step.
    assign set_v   = i_src & (~edge_en | ~src_d);
    assign cand[0] = pending & enable & ~route;
    assign cand[1] = pending & enable & route;

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            win_vld[l] = 1'b0;
            win_id[l]  = '0;
            for (int i = N_SRC - 1; i >= 0; i--) begin
                if (cand[l][i]) begin
                    win_vld[l] = 1'b1;
                    win_id[l]  = 5'(i);
                end
            end
            take[l] = rd && (word == 3'(4 + l)) && (state[l] == S_ASSERT) && win_vld[l];
            done[l] = wr && (word == 3'(4 + l)) && (state[l] == S_SERVICE)
                      && (wb.dat[4:0] == rec_id[l] + 5'd1);
        end
    end

    always_comb begin
        clr_v = '0;
        for (int l = 0; l < 2; l++)
            if (take[l]) clr_v = clr_v | (N_SRC'(1) << win_id[l]);
    end

    always_comb begin
        rdata = '0;
        case (word)
            3'd0: rdata[N_SRC-1:0] = pending;
            3'd1: rdata[N_SRC-1:0] = enable;
            3'd2: rdata[N_SRC-1:0] = route;
            3'd3: rdata[N_SRC-1:0] = edge_en;
            3'd4: if (take[0]) rdata[4:0] = win_id[0] + 5'd1;
            3'd5: if (take[1]) rdata[4:0] = win_id[1] + 5'd1;
            3'd6: rdata[1:0] = status;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            src_d   <= '0;
            pending <= '0;
            enable  <= '0;
            route   <= '0;
            edge_en <= '0;
            wb.ack  <= 1'b0;
            wb.rdt  <= '0;
        end else begin
            src_d   <= i_src;
            pending <= (pending & ~clr_v) | set_v;
            wb.ack  <= wb.cyc & wb.stb & ~wb.ack;
            if (rd) wb.rdt <= rdata;
            if (wr) begin
                case (word)
                    3'd1: enable  <= wb.dat[N_SRC-1:0];
                    3'd2: route   <= wb.dat[N_SRC-1:0];
                    3'd3: edge_en <= wb.dat[N_SRC-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= '0;
            rec_id <= '0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                case (state[l])
                    S_IDLE:
                        if (win_vld[l]) state[l] <= S_ASSERT;
                    S_ASSERT:
                        if (take[l]) begin
                            state[l]  <= S_SERVICE;
                            rec_id[l] <= win_id[l];
                        end else if (!win_vld[l]) begin
                            state[l] <= S_IDLE;
                        end
                    S_SERVICE:
                        if (done[l] || tmo[l]) state[l] <= S_IDLE;
                    default:
                        state[l] <= S_IDLE;
                endcase
            end
        end
    end

`ifdef IRQ_ROUTER_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    logic [1:0][CW-1:0] cnt;

    // A completion landing on the expiry cycle wins; the watchdog does not fire.
    always_comb begin
        for (int l = 0; l < 2; l++)
            tmo[l] = (state[l] == S_SERVICE) && !done[l] && (cnt[l] == CW'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt    <= '0;
            status <= '0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (take[l])                     cnt[l] <= '0;
                else if (state[l] == S_SERVICE)  cnt[l] <= cnt[l] + 1'b1;
                status[l] <= tmo[l] | (status[l] & ~(wr && (word == 3'd6) && wb.dat[l]));
            end
        end
    end
`else
    assign tmo    = '0;
    assign status = '0;
`endif

    assign o_irq3 = (state[0] == S_ASSERT);
    assign o_irq4 = (state[1] == S_ASSERT);

    assign unused_bits = ^{wb.adr[1:0], wb.sel[3:1], wb.dat, (TIMEOUT_CYCLES != 0)};
endmodule

// File: tb/tb_swervolf_irq_router.sv
// Directed and randomized checks of swervolf_irq_router against a rule-level reference model.
module tb_swervolf_irq_router;
    localparam int N = 4;
    localparam logic [4:0] A_PEND = 5'h00, A_EN = 5'h04, A_ROUTE = 5'h08, A_EDGE = 5'h0C;
    localparam logic [4:0] A_CL3 = 5'h10, A_CL4 = 5'h14, A_STAT = 5'h18;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] src = '0;
    logic         irq3, irq4;
    logic         ack_irq3, ack_irq4;
    logic [31:0]  d;
    int           ncmp = 0;
    int           nfail = 0;

    // reference model state
    logic [N-1:0] mpend, msrc_d, men, mroute, medge;

    swervolf_irq_router_if wb();

    swervolf_irq_router #(.N_SRC(N), .TIMEOUT_CYCLES(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .i_src (src),
        .wb    (wb),
        .o_irq3(irq3),
        .o_irq4(irq4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                       output logic [31:0] rdt);
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we; wb.adr = adr; wb.dat = dat; wb.sel = 4'hF;
        tick();
        chk("ack", wb.ack, 1);
        rdt = wb.rdt; ack_irq3 = irq3; ack_irq4 = irq4;
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [4:0] adr, input logic [31:0] dat);
        logic [31:0] dummy;
        bus(1'b1, adr, dat, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] adr, input logic [31:0] exp);
        logic [31:0] v;
        bus(1'b0, adr, 32'h0, v);
        chk(tag, v, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1; src = '0;
        tick(); tick();
        rst = 1'b0;
        mpend = '0; msrc_d = '0;
    endtask

    // one cycle of source activity, applying the set rules to the model
    task automatic src_step(input logic [N-1:0] v);
        src = v;
        mpend  = mpend | (v & ~(medge & msrc_d));
        msrc_d = v;
        tick();
    endtask

    function automatic int lowest(input logic [N-1:0] c);
        for (int i = 0; i < N; i++) if (c[i]) return i;
        return -1;
    endfunction

    task automatic drain(input int line);
        logic [N-1:0] c;
        logic [31:0]  v;
        logic [4:0]   a;
        int           id;
        a = (line == 0) ? A_CL3 : A_CL4;
        for (int k = 0; k <= N; k++) begin
            c = mpend & men & ((line == 0) ? ~mroute : mroute);
            if (c == '0) break;
            id = lowest(c);
            chk("rnd_irq_req", (line == 0) ? irq3 : irq4, 1);
            bus(1'b0, a, 32'h0, v);
            chk("rnd_claim_id", v, 32'(id + 1));
            mpend = mpend & ~(N'(1) << id);
            wr(a, 32'(id + 1));
        end
        rd_chk("rnd_claim_empty", a, 0);
        chk("rnd_irq_idle", (line == 0) ? irq3 : irq4, 0);
    endtask

    initial begin
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.adr = '0; wb.dat = '0; wb.sel = '0;
        medge = '0; men = '0; mroute = '0;
        do_reset();
        chk("rst_irq3", irq3, 0);
        chk("rst_irq4", irq4, 0);
        chk("rst_ack", wb.ack, 0);
        chk("rst_rdt", wb.rdt, 0);
        rd_chk("rst_pend", A_PEND, 0);
        rd_chk("rst_en", A_EN, 0);
        rd_chk("rst_stat", A_STAT, 0);

        // single edge source on IRQ3
        wr(A_EN, 32'h1); wr(A_EDGE, 32'h1); wr(A_ROUTE, 32'h0);
        rd_chk("en_upper_bits", A_EN, 32'h1);
        src = 4'b0001; tick();
        chk("edge_irq3_t1", irq3, 0);
        src = 4'b0000; tick();
        chk("edge_irq3_t2", irq3, 1);
        rd_chk("claim3_first", A_CL3, 1);
        chk("claim3_irq_drop", ack_irq3, 0);
        rd_chk("pend_cleared", A_PEND, 0);
        wr(A_CL3, 32'h1);
        chk("complete_idle", irq3, 0);
        tick();
        chk("complete_idle2", irq3, 0);

        // two level sources: priority, then reassert after complete
        wr(A_EDGE, 32'h0); wr(A_EN, 32'hF);
        src = 4'b1010; tick(); tick();
        chk("lvl_irq3", irq3, 1);
        src = 4'b1000;
        rd_chk("lvl_claim_2", A_CL3, 2);
        chk("lvl_in_service", irq3, 0);
        wr(A_CL3, 32'h2);
        chk("lvl_reassert", irq3, 1);
        src = 4'b0000;
        rd_chk("lvl_claim_4", A_CL3, 4);
        wr(A_CL3, 32'h4);
        chk("lvl_idle", irq3, 0);
        rd_chk("lvl_pend", A_PEND, 0);

        // both lines at once
        wr(A_EDGE, 32'hF); wr(A_ROUTE, 32'h4);
        src = 4'b0101; tick();
        src = 4'b0000; tick();
        chk("dual_irq3", irq3, 1);
        chk("dual_irq4", irq4, 1);
        rd_chk("dual_claim3", A_CL3, 1);
        rd_chk("dual_claim4", A_CL4, 3);
        wr(A_CL4, 32'h3);
        wr(A_CL3, 32'h1);
        chk("dual_idle3", irq3, 0);
        chk("dual_idle4", irq4, 0);

        // wrong complete, claim read during service, pulse while in service
        wr(A_ROUTE, 32'h0); wr(A_EN, 32'h1);
        src = 4'b0001; tick(); src = 4'b0000; tick();
        rd_chk("svc_claim", A_CL3, 1);
        wr(A_CL3, 32'h2);
        chk("svc_bad_complete", irq3, 0);
        rd_chk("svc_claim_zero", A_CL3, 0);
        rd_chk("svc_pend0", A_PEND, 0);
        src = 4'b0001; tick(); src = 4'b0000; tick();
        rd_chk("svc_pend_set", A_PEND, 1);
        chk("svc_no_irq", irq3, 0);
        rd_chk("svc_claim_zero2", A_CL3, 0);
        rd_chk("svc_pend_kept", A_PEND, 1);
        wr(A_CL3, 32'h1);
        chk("svc_complete_ack_irq", ack_irq3, 0);
        chk("svc_reassert", irq3, 1);

        // reset while asserting, with a claim read in flight
        rst = 1'b1;
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = A_CL3;
        tick();
        chk("midrst_irq3", irq3, 0);
        chk("midrst_ack", wb.ack, 0);
        chk("midrst_rdt", wb.rdt, 0);
        rst = 1'b0; wb.cyc = 1'b0; wb.stb = 1'b0;
        tick();
        rd_chk("midrst_pend", A_PEND, 0);
        rd_chk("midrst_en", A_EN, 0);
        chk("midrst_irq3_after", irq3, 0);

        wr(A_STAT, 32'h3);
        rd_chk("stat_wr_noeffect", A_STAT, 0);

`ifdef IRQ_ROUTER_TIMEOUT_EN
        begin
            bit seen;
            wr(A_EN, 32'h1); wr(A_EDGE, 32'h1);
            src = 4'b0001; tick(); src = 4'b0000; tick();
            rd_chk("tmo_claim", A_CL3, 1);
            src = 4'b0001; tick(); src = 4'b0000; tick();
            repeat (8) tick();
            chk("tmo_still_service", irq3, 0);
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                tick();
                if (irq3) seen = 1'b1;
            end
            chk("tmo_line_idle", seen, 1);
            rd_chk("tmo_status", A_STAT, 1);
            wr(A_STAT, 32'h1);
            rd_chk("tmo_status_clr", A_STAT, 0);
        end
`endif

        // randomized configurations and source activity
        for (int it = 0; it < 6; it++) begin
            do_reset();
            men = N'($urandom); mroute = N'($urandom); medge = N'($urandom);
            wr(A_EN, 32'(men)); wr(A_ROUTE, 32'(mroute)); wr(A_EDGE, 32'(medge));
            repeat (6) src_step(N'($urandom));
            src_step('0);
            rd_chk("rnd_pend", A_PEND, 32'(mpend));
            drain(0);
            drain(1);
            rd_chk("rnd_pend_left", A_PEND, 32'(mpend));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
